serial_bus_master: RTL and testbench

UART-driven bus initiator: receives 8N1 command frames on a serial line, runs single-word Vermibus read or write transactions, and returns acknowledge or read data on a serial transmit line. It is the host-side counterpart of the Vermicom responder. It lets an external debugger or loader peek and poke memory and peripherals without the CPU, and it sits beside the core as an additional initiator on the interconnect.

---
 rtl/serial_bus_master.sv | 231 +++++++++++++++++++++++
 tb/tb_serial_bus_master.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bus_master.sv
// UART-driven single-word bus initiator: 8N1 command frames in on rx,
// Vermibus read/write out, ack / NAK / read data back on tx.
module serial_bus_master #(
  parameter int unsigned DIVISION = 867
) (
  input  logic        clk,
  input  logic        reset,
  output logic        bus_valid,
  output logic [31:0] bus_address,
  output logic [3:0]  bus_wstrobe,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  input  logic        rx,
  output logic        tx,
  output logic        busy
);
  localparam int unsigned CW = (DIVISION < 1) ? 1 : $clog2(DIVISION + 1);
  localparam logic [CW-1:0] DIV_C  = CW'(DIVISION);
  localparam logic [CW-1:0] HALF_C = CW'(DIVISION / 2);
  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_R = 8'h52;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

  typedef enum logic [2:0] {ST_CMD, ST_ADDR, ST_DATA, ST_BUS, ST_REPLY} state_t;

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic          rx_active_q, rx_active_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [3:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_byte_vld, rx_frame_err;

  state_t        state_q, state_d;
  logic [7:0]    op_q, op_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrobe_q, wstrobe_d;
  logic [31:0]   reply_q, reply_d;
  logic [1:0]    left_q, left_d;
  logic [9:0]    tx_shift_q, tx_shift_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic          load_en;
  logic [7:0]    load_byte;

  // Receiver: bit 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
  always_comb begin
    rx_active_d  = rx_active_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_byte_vld  = 1'b0;
    rx_frame_err = 1'b0;
    if (!rx_active_q) begin
      if (rx_prev_q && !rx_sync_q) begin
        rx_active_d = 1'b1;
        rx_cnt_d    = DIV_C;
        rx_bit_d    = 4'd0;
      end
    end else begin
      if (rx_cnt_q == HALF_C) begin
        if (rx_bit_q == 4'd9) begin
          rx_active_d  = 1'b0;
          rx_byte_vld  = rx_sync_q;
          rx_frame_err = !rx_sync_q;
        end else if (rx_bit_q != 4'd0) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        end
      end
      if (rx_cnt_q == '0) begin
        rx_cnt_d = DIV_C;
        rx_bit_d = rx_bit_q + 4'd1;
      end else begin
        rx_cnt_d = rx_cnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrobe_d  = wstrobe_q;
    reply_d    = reply_q;
    left_d     = left_q;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    load_en    = 1'b0;
    load_byte  = 8'h00;
    case (state_q)
      ST_CMD: begin
        if (rx_byte_vld) begin
          op_d  = rx_shift_q;
          cnt_d = 2'd0;
          if (rx_shift_q == OP_W || rx_shift_q == OP_R) begin
            state_d = ST_ADDR;
          end else begin
            state_d   = ST_REPLY;
            left_d    = 2'd0;
            load_en   = 1'b1;
            load_byte = NAK;
          end
        end
      end
      ST_ADDR: begin
        if (rx_byte_vld) begin
          addr_d = {rx_shift_q, addr_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (op_q == OP_W) begin
              state_d = ST_DATA;
            end else begin
              state_d   = ST_BUS;
              wstrobe_d = 4'h0;
            end
          end
        end
      end
      ST_DATA: begin
        if (rx_byte_vld) begin
          wdata_d = {rx_shift_q, wdata_q[31:8]};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d   = ST_BUS;
            wstrobe_d = 4'hF;
          end
        end
      end
      ST_BUS: begin
        if (bus_ready) begin
          state_d = ST_REPLY;
          load_en = 1'b1;
          if (op_q == OP_W) begin
            left_d    = 2'd0;
            load_byte = ACK;
          end else begin
            left_d    = 2'd3;
            reply_d   = bus_rdata;
            load_byte = bus_rdata[7:0];
          end
        end
      end
      ST_REPLY: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = DIV_C;
          if (tx_bit_q == 4'd9) begin
            tx_bit_d = 4'd0;
            if (left_q == 2'd0) begin
              state_d = ST_CMD;
            end else begin
              // Next byte starts straight after this stop bit, no idle gap.
              left_d    = left_q - 2'd1;
              reply_d   = {8'h00, reply_q[31:8]};
              load_en   = 1'b1;
              load_byte = reply_q[15:8];
            end
          end else begin
            tx_bit_d   = tx_bit_q + 4'd1;
            tx_shift_d = {1'b1, tx_shift_q[9:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end
      end
      default: state_d = ST_CMD;
    endcase
    if (rx_frame_err && (state_q == ST_CMD || state_q == ST_ADDR || state_q == ST_DATA)) begin
      state_d = ST_CMD;
    end
    if (load_en) begin
      tx_shift_d = {1'b1, load_byte, 1'b0};
      tx_cnt_d   = DIV_C;
      tx_bit_d   = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_active_q <= 1'b0;
      rx_cnt_q    <= '0;
      rx_bit_q    <= 4'd0;
      rx_shift_q  <= 8'h00;
      state_q     <= ST_CMD;
      op_q        <= 8'h00;
      cnt_q       <= 2'd0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      wstrobe_q   <= 4'h0;
      reply_q     <= 32'h0;
      left_q      <= 2'd0;
      tx_shift_q  <= '1;
      tx_cnt_q    <= '0;
      tx_bit_q    <= 4'd0;
    end else begin
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      rx_active_q <= rx_active_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrobe_q   <= wstrobe_d;
      reply_q     <= reply_d;
      left_q      <= left_d;
      tx_shift_q  <= tx_shift_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
    end
  end

  assign bus_valid   = (state_q == ST_BUS);
  assign bus_address = addr_q;
  assign bus_wdata   = wdata_q;
  assign bus_wstrobe = wstrobe_q;
  assign tx          = tx_shift_q[0];
  assign busy        = (state_q != ST_CMD);
endmodule

// File: tb/tb_serial_bus_master.sv
// Scoreboard bench for serial_bus_master: a command-level model queues the
// expected bus accesses and reply bytes; bus and tx monitors pop and compare.
`timescale 1ns/1ps
module tb_serial_bus_master;
  localparam int DIV   = 3;
  localparam int BITC  = DIV + 1;
  localparam int FRAME = 10 * BITC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bus_valid;
  logic [31:0] bus_address, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrobe;
  logic        bus_ready;
  logic        rx = 1'b1;
  logic        tx, busy;

  serial_bus_master #(.DIVISION(DIV)) dut (
    .clk(clk), .reset(reset),
    .bus_valid(bus_valid), .bus_address(bus_address), .bus_wstrobe(bus_wstrobe),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .rx(rx), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        wr;
    int          hold;
  } bus_exp_t;
  typedef struct {
    logic [7:0] b;
    logic       is_first;
    logic       is_last;
  } tx_exp_t;

  bus_exp_t bus_q[$];
  tx_exp_t  tx_q[$];

  int          ready_delay = 0;
  logic        ready_reg = 1'b0;
  logic [31:0] cur_rdata = 32'h0;
  assign bus_ready = ready_reg;
  assign bus_rdata = cur_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Responder and bus monitor: ready after ready_delay extra valid cycles.
  int          hold = 0;
  logic [31:0] h_addr, h_data;
  logic [3:0]  h_strb;
  bus_exp_t    be;
  always @(negedge clk) begin
    if (bus_valid === 1'b1) begin
      hold++;
      if (hold == 1) begin
        h_addr = bus_address;
        h_data = bus_wdata;
        h_strb = bus_wstrobe;
      end else begin
        check("addr_stable", bus_address, h_addr);
        check("wdata_stable", bus_wdata, h_data);
        check("wstrobe_stable", 32'(bus_wstrobe), 32'(h_strb));
      end
      ready_reg = (hold >= ready_delay + 1);
      if (ready_reg) begin
        if (bus_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL bus_unexpected: got access to %h, required none", bus_address);
        end else begin
          be = bus_q.pop_front();
          check("bus_addr", bus_address, be.addr);
          check("bus_wstrobe", 32'(bus_wstrobe), 32'(be.strb));
          if (be.wr) check("bus_wdata", bus_wdata, be.data);
          check("valid_cycles", 32'(hold), 32'(be.hold));
        end
      end
    end else begin
      hold = 0;
      ready_reg = 1'b0;
    end
  end

  // Serial monitor on tx: decodes frames and checks spacing and busy release.
  initial begin : tx_mon
    tx_exp_t    te;
    logic [7:0] got;
    logic       stop;
    int         st;
    int         last_start;
    last_start = -1000;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        st = cycle;
        repeat (BITC / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BITC) @(negedge clk);
          got[i] = tx;
        end
        repeat (BITC) @(negedge clk);
        stop = tx;
        if (tx_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL tx_unexpected: got byte %h, required none", got);
        end else begin
          te = tx_q.pop_front();
          check("tx_byte", 32'(got), 32'(te.b));
          check("tx_stop", 32'(stop), 32'd1);
          if (!te.is_first) check("tx_back_to_back", 32'(st - last_start), 32'(FRAME));
          if (te.is_last) begin
            repeat (BITC - BITC / 2 - 1) @(negedge clk);
            check("busy_last_stop", 32'(busy), 32'd1);
            @(negedge clk);
            check("busy_after_reply", 32'(busy), 32'd0);
          end
        end
        last_start = st;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (BITC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BITC) @(negedge clk);
    end
    rx = stop;
    repeat (BITC) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input int gap);
    send_byte(op, 1'b1);
    if (op == 8'h57 || op == 8'h52) begin
      for (int k = 0; k < 4; k++) begin
        repeat (gap) @(negedge clk);
        send_byte(addr[8*k +: 8], 1'b1);
      end
    end
    if (op == 8'h57) begin
      for (int k = 0; k < 4; k++) begin
        repeat (gap) @(negedge clk);
        send_byte(data[8*k +: 8], 1'b1);
      end
    end
  endtask

  task automatic push_tx(input logic [7:0] b, input logic f, input logic l);
    tx_exp_t t;
    t.b = b;
    t.is_first = f;
    t.is_last = l;
    tx_q.push_back(t);
  endtask

  // Reference model: what one command should produce on the bus and on tx.
  task automatic expect_cmd(input logic [7:0] op, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] rdata, input int delay);
    bus_exp_t e;
    cur_rdata   = rdata;
    ready_delay = delay;
    if (op == 8'h57) begin
      e.addr = addr; e.data = data; e.strb = 4'hF; e.wr = 1'b1; e.hold = delay + 1;
      bus_q.push_back(e);
      push_tx(8'h06, 1'b1, 1'b1);
    end else if (op == 8'h52) begin
      e.addr = addr; e.data = 32'h0; e.strb = 4'h0; e.wr = 1'b0; e.hold = delay + 1;
      bus_q.push_back(e);
      for (int k = 0; k < 4; k++) push_tx(rdata[8*k +: 8], k == 0, k == 3);
    end else begin
      push_tx(8'h15, 1'b1, 1'b1);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    repeat (4) @(negedge clk);
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: got busy %b, required 0 within 3000 cycles", busy);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic issue(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] rdata, input int delay, input int gap);
    expect_cmd(op, addr, data, rdata, delay);
    send_cmd(op, addr, data, gap);
    wait_idle();
  endtask

  initial begin : stim
    logic [7:0]  op;
    logic [31:0] a, d, r;
    int          n;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(bus_valid), 32'd0);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", bus_address, 32'h0);
    check("rst_wdata", bus_wdata, 32'h0);
    check("rst_wstrobe", 32'(bus_wstrobe), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    issue(8'h57, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 0, 0);
    issue(8'h52, 32'h0000_0004, 32'h0, 32'h1234_5678, 5, 0);
    issue(8'h41, 32'h0, 32'h0, 32'h0, 0, 0);

    // Corrupted stop bit on an opcode, then a clean read.
    send_byte(8'h57, 1'b0);
    repeat (2 * BITC) @(negedge clk);
    issue(8'h52, 32'hA5A5_0102, 32'h0, 32'hCAFE_F00D, 1, 1);

    // Reset while the read is stalled on ready.
    ready_delay = 100000;
    send_cmd(8'h52, 32'h0000_0100, 32'h0, 0);
    n = 0;
    while (bus_valid !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("stall_valid", 32'(bus_valid), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_valid", 32'(bus_valid), 32'd0);
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    ready_delay = 0;
    repeat (3) @(negedge clk);
    issue(8'h52, 32'h0000_0200, 32'h0, 32'h0BAD_1DEA, 0, 0);

    // A byte arriving mid-reply must be ignored.
    expect_cmd(8'h52, 32'h1000_0008, 32'h0, 32'h8899_AABB, 0);
    send_cmd(8'h52, 32'h1000_0008, 32'h0, 0);
    n = 0;
    while (bus_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reply_bus_done", 32'(bus_q.size()), 32'd0);
    repeat (8) @(negedge clk);
    send_byte(8'h41, 1'b1);
    wait_idle();
    issue(8'h57, 32'h2000_0003, 32'h0102_0304, 32'h0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 2))
        0: op = 8'h57;
        1: op = 8'h52;
        default: begin
          op = 8'($urandom);
          while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
        end
      endcase
      a = $urandom;
      d = $urandom;
      r = $urandom;
      issue(op, a, d, r, $urandom_range(0, 4), $urandom_range(0, 3));
    end

    repeat (10) @(negedge clk);
    check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
    check("tx_queue_drained", 32'(tx_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
